// File: rtl/faculty_pkg.sv
// -----------------------------------------------------------------------------
// faculty_pkg
// Shared definitions for the fighter game-level sequencer.
//   stage_t       : the four display stages driven onto the colour mapper.
//   MAX_HEALTH    : hit points per side at round start (thermometer width).
//   INVULN_FRAMES : post-hit invulnerability window, in frames.
//   RESULT_FRAMES : how long the WIN/LOSE screen is held, in frames.
//   FRAME_CNT_W   : width of the frame timers.
//   to_thermo()   : HP value -> MAX_HEALTH-wide thermometer mask.
// -----------------------------------------------------------------------------
package faculty_pkg;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_BATTLE = 2'd1,
    ST_WIN    = 2'd2,
    ST_LOSE   = 2'd3
  } stage_t;

  localparam int MAX_HEALTH    = 5;
  localparam int INVULN_FRAMES = 30;
  localparam int RESULT_FRAMES = 180;
  localparam int FRAME_CNT_W   = 8;

  // Bit i of the mask is set iff hp > i, so the bar fills from bit 0 upward.
  function automatic logic [MAX_HEALTH-1:0] to_thermo(input int unsigned hp);
    logic [MAX_HEALTH-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_HEALTH; i++) begin
      mask[i] = (hp > i);
    end
    return mask;
  endfunction

endpackage : faculty_pkg

// File: rtl/health_tracker.sv
// -----------------------------------------------------------------------------
// health_tracker
// Hit-point bookkeeping for one side (player or NPC).
//   clk          : system clock, rising edge.
//   reset        : synchronous, active-high.
//   frame_tick   : one-cycle pulse per frame; ages the invulnerability timer.
//   reload       : restore full HP and clear the invulnerability timer.
//   enable       : high while the stage is BATTLE; hits and timer aging only
//                  count when set.
//   hit          : one-cycle pulse, this side was struck.
//   thermo       : registered thermometer of the current HP.
//   hp_next_zero : HP will be 0 after the coming edge (combinational, feeds
//                  the stage FSM so the stage flips on the same edge).
// -----------------------------------------------------------------------------
module health_tracker #(
  parameter int MAX_HEALTH    = faculty_pkg::MAX_HEALTH,
  parameter int INVULN_FRAMES = faculty_pkg::INVULN_FRAMES,
  parameter int FRAME_CNT_W   = faculty_pkg::FRAME_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  reload,
  input  logic                  enable,
  input  logic                  hit,
  output logic [MAX_HEALTH-1:0] thermo,
  output logic                  hp_next_zero
);

  import faculty_pkg::*;

  localparam int HP_W = $clog2(MAX_HEALTH + 1);

  logic [HP_W-1:0]        hp_d, hp_q;
  logic [FRAME_CNT_W-1:0] inv_d, inv_q;
  logic [MAX_HEALTH-1:0]  thermo_d, thermo_q;
  logic                   hit_ok;

  // NOTE: every signal written here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    hp_d     = hp_q;
    inv_d    = inv_q;
    thermo_d = '0;

    // A hit counts only against the pre-tick timer value, so a hit that
    // lands on the tick taking the timer from 1 to 0 is still blocked.
    hit_ok = enable && hit && (inv_q == '0);

    if (reload) begin
      hp_d  = HP_W'(MAX_HEALTH);
      inv_d = '0;
    end else if (hit_ok) begin
      if (hp_q != '0) begin
        hp_d = hp_q - HP_W'(1);
      end
      inv_d = FRAME_CNT_W'(INVULN_FRAMES);
    end else if (enable && frame_tick && (inv_q != '0)) begin
      inv_d = inv_q - FRAME_CNT_W'(1);
    end

    for (int i = 0; i < MAX_HEALTH; i++) begin
      thermo_d[i] = (hp_d > HP_W'(i));
    end
  end

  assign hp_next_zero = (hp_d == '0);
  assign thermo       = thermo_q;

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      hp_q     <= HP_W'(MAX_HEALTH);
      inv_q    <= '0;
      thermo_q <= '1;
    end else begin
      hp_q     <= hp_d;
      inv_q    <= inv_d;
      thermo_q <= thermo_d;
    end
  end

endmodule : health_tracker

// File: rtl/stage_controller.sv
// -----------------------------------------------------------------------------
// stage_controller
// Game-level sequencer: START -> BATTLE -> WIN/LOSE -> START.
//   Clk           : system clock, rising edge.
//   Reset         : synchronous, active-high; dominates all other inputs.
//   frame_tick    : one-cycle pulse at vertical-blank start.
//   start_key     : level from the keycode decoder; rising edge used.
//   player_hit    : one-cycle pulse, NPC projectile struck the player.
//   npc_hit       : one-cycle pulse, player projectile struck the NPC.
//   start_l/battle_l/win_l/lose_l : one-hot registered stage levels.
//   player_health : registered thermometer of player HP.
//   npc_health    : registered thermometer of NPC HP.
//   round_init    : one-cycle pulse on START -> BATTLE.
//   freeze        : high whenever the stage is not BATTLE.
// -----------------------------------------------------------------------------
module stage_controller #(
  parameter int MAX_HEALTH    = faculty_pkg::MAX_HEALTH,
  parameter int INVULN_FRAMES = faculty_pkg::INVULN_FRAMES,
  parameter int RESULT_FRAMES = faculty_pkg::RESULT_FRAMES,
  parameter int FRAME_CNT_W   = faculty_pkg::FRAME_CNT_W
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic                  start_key,
  input  logic                  player_hit,
  input  logic                  npc_hit,
  output logic                  start_l,
  output logic                  battle_l,
  output logic                  win_l,
  output logic                  lose_l,
  output logic [MAX_HEALTH-1:0] player_health,
  output logic [MAX_HEALTH-1:0] npc_health,
  output logic                  round_init,
  output logic                  freeze
);

  import faculty_pkg::*;

  localparam logic [1:0] S_START  = ST_START;
  localparam logic [1:0] S_BATTLE = ST_BATTLE;
  localparam logic [1:0] S_WIN    = ST_WIN;
  localparam logic [1:0] S_LOSE   = ST_LOSE;

  localparam logic [FRAME_CNT_W-1:0] RESULT_LAST = FRAME_CNT_W'(RESULT_FRAMES - 1);

  logic [1:0]             state_d, state_q;
  logic [FRAME_CNT_W-1:0] res_d, res_q;
  logic                   start_key_q;
  logic                   round_init_d, round_init_q;
  logic [3:0]             stage_lv_d, stage_lv_q;   // {start, battle, win, lose}
  logic                   freeze_d, freeze_q;

  logic start_edge;
  logic in_result;
  logic leave_result;
  logic in_battle;
  logic reload;
  logic player_zero;
  logic npc_zero;

  assign start_edge = start_key && !start_key_q;
  assign in_battle  = (state_q == S_BATTLE);
  assign in_result  = (state_q == S_WIN) || (state_q == S_LOSE);

  // The exit from WIN/LOSE is derived without the HP flags so that reload
  // (which feeds the trackers) never depends on hp_next_zero combinationally.
  assign leave_result = in_result &&
                        (start_edge || (frame_tick && (res_q == RESULT_LAST)));

  // HP is held at full throughout START (and on the edge that enters it),
  // and the START -> BATTLE edge also reloads; WIN/LOSE keep the final bar.
  assign reload = (state_q == S_START) || leave_result;

  health_tracker #(
    .MAX_HEALTH    (MAX_HEALTH),
    .INVULN_FRAMES (INVULN_FRAMES),
    .FRAME_CNT_W   (FRAME_CNT_W)
  ) u_player (
    .clk          (Clk),
    .reset        (Reset),
    .frame_tick   (frame_tick),
    .reload       (reload),
    .enable       (in_battle),
    .hit          (player_hit),
    .thermo       (player_health),
    .hp_next_zero (player_zero)
  );

  health_tracker #(
    .MAX_HEALTH    (MAX_HEALTH),
    .INVULN_FRAMES (INVULN_FRAMES),
    .FRAME_CNT_W   (FRAME_CNT_W)
  ) u_npc (
    .clk          (Clk),
    .reset        (Reset),
    .frame_tick   (frame_tick),
    .reload       (reload),
    .enable       (in_battle),
    .hit          (npc_hit),
    .thermo       (npc_health),
    .hp_next_zero (npc_zero)
  );

  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    round_init_d = 1'b0;

    case (state_q)
      S_START: begin
        res_d = '0;
        if (start_edge) begin
          state_d      = S_BATTLE;
          round_init_d = 1'b1;
        end
      end

      S_BATTLE: begin
        // Result timer is zero on entry to WIN/LOSE.
        res_d = '0;
        // Player death is checked first: a double KO goes to the NPC.
        if (player_zero) begin
          state_d = S_LOSE;
        end else if (npc_zero) begin
          state_d = S_WIN;
        end
      end

      S_WIN, S_LOSE: begin
        if (leave_result) begin
          state_d = S_START;
          res_d   = '0;
        end else if (frame_tick) begin
          res_d = res_q + FRAME_CNT_W'(1);
        end
      end

      default: begin
        state_d = S_START;
        res_d   = '0;
      end
    endcase

    stage_lv_d = {(state_d == S_START), (state_d == S_BATTLE),
                  (state_d == S_WIN),   (state_d == S_LOSE)};
    freeze_d   = (state_d != S_BATTLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_START;
      res_q        <= '0;
      start_key_q  <= 1'b0;
      round_init_q <= 1'b0;
      stage_lv_q   <= 4'b1000;
      freeze_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      start_key_q  <= start_key;
      round_init_q <= round_init_d;
      stage_lv_q   <= stage_lv_d;
      freeze_q     <= freeze_d;
    end
  end

  assign start_l    = stage_lv_q[3];
  assign battle_l   = stage_lv_q[2];
  assign win_l      = stage_lv_q[1];
  assign lose_l     = stage_lv_q[0];
  assign round_init = round_init_q;
  assign freeze     = freeze_q;

endmodule : stage_controller

// File: tb/tb_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_stage_controller
// Directed bench for stage_controller: a short table of per-cycle vectors
// for the opening of a round, followed by hand-written multi-cycle sequences
// for invulnerability timing, result hold, double KO and mid-battle reset.
// -----------------------------------------------------------------------------
module tb_stage_controller;

  localparam logic [3:0] STG_START  = 4'b1000;
  localparam logic [3:0] STG_BATTLE = 4'b0100;
  localparam logic [3:0] STG_WIN    = 4'b0010;
  localparam logic [3:0] STG_LOSE   = 4'b0001;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_key = 1'b0;
  logic       player_hit = 1'b0;
  logic       npc_hit = 1'b0;
  logic       start_l, battle_l, win_l, lose_l;
  logic [4:0] player_health, npc_health;
  logic       round_init, freeze;

  int errors = 0;
  int checks = 0;

  stage_controller dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .start_key     (start_key),
    .player_hit    (player_hit),
    .npc_hit       (npc_hit),
    .start_l       (start_l),
    .battle_l      (battle_l),
    .win_l         (win_l),
    .lose_l        (lose_l),
    .player_health (player_health),
    .npc_health    (npc_health),
    .round_init    (round_init),
    .freeze        (freeze)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       sk;
    logic       ph;
    logic       nh;
    logic       ft;
    logic [3:0] stg;
    logic [4:0] p;
    logic [4:0] n;
    logic       ri;
    logic       fr;
  } vec_t;

  vec_t vecs [8];

  // Drive one cycle of inputs, let the edge happen, then sample 1 ns later.
  task automatic apply(input logic rst, input logic sk, input logic ph,
                       input logic nh, input logic ft);
    Reset      = rst;
    start_key  = sk;
    player_hit = ph;
    npc_hit    = nh;
    frame_tick = ft;
    @(posedge Clk);
    #1;
    Reset      = 1'b0;
    player_hit = 1'b0;
    npc_hit    = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, start_key, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [3:0] es,
                       input logic [4:0] ep, input logic [4:0] en,
                       input logic eri, input logic efr);
    logic [15:0] got, exp;
    got = {start_l, battle_l, win_l, lose_l, player_health, npc_health, round_init, freeze};
    exp = {es, ep, en, eri, efr};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got stage=%b p=%b n=%b ri=%b fr=%b, expected stage=%b p=%b n=%b ri=%b fr=%b",
               name, got[15:12], got[11:7], got[6:2], got[1], got[0],
               es, ep, en, eri, efr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ri_seen;

    // rst sk ph nh ft | stage  player    npc      ri fr
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, STG_BATTLE, 5'b11111, 5'b11111, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, STG_BATTLE, 5'b11111, 5'b11111, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, STG_BATTLE, 5'b11111, 5'b01111, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, STG_BATTLE, 5'b11111, 5'b01111, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, STG_BATTLE, 5'b01111, 5'b01111, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, STG_BATTLE, 5'b01111, 5'b01111, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, STG_BATTLE, 5'b01111, 5'b01111, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, STG_BATTLE, 5'b01111, 5'b01111, 1'b0, 1'b0};

    // ---- Reset and idle START ----
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset", STG_START, 5'b11111, 5'b11111, 1'b0, 1'b1);
    ri_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ri_seen = ri_seen | round_init;
    end
    check("idle_start", STG_START, 5'b11111, 5'b11111, 1'b0, 1'b1);
    checks++;
    if (ri_seen !== 1'b0) begin
      errors++;
      $display("FAIL idle_round_init: got pulse=%b, expected pulse=0", ri_seen);
    end

    // ---- Round opening: table-driven ----
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].rst, vecs[i].sk, vecs[i].ph, vecs[i].nh, vecs[i].ft);
      check($sformatf("vec%0d", i), vecs[i].stg, vecs[i].p, vecs[i].n, vecs[i].ri, vecs[i].fr);
    end

    // ---- Invulnerability window (both timers at 30) ----
    tick_n(5);
    apply(1'b0, start_key, 1'b0, 1'b1, 1'b0);
    check("npc_hit_invuln", STG_BATTLE, 5'b01111, 5'b01111, 1'b0, 1'b0);
    tick_n(25);
    apply(1'b0, start_key, 1'b0, 1'b1, 1'b0);
    check("npc_hit_after30", STG_BATTLE, 5'b01111, 5'b00111, 1'b0, 1'b0);
    tick_n(29);
    apply(1'b0, start_key, 1'b0, 1'b1, 1'b1);
    check("hit_on_last_tick", STG_BATTLE, 5'b01111, 5'b00111, 1'b0, 1'b0);
    apply(1'b0, start_key, 1'b0, 1'b1, 1'b0);
    check("hit_timer_zero", STG_BATTLE, 5'b01111, 5'b00011, 1'b0, 1'b0);

    // ---- NPC knocked out -> WIN, then result hold ----
    tick_n(30);
    apply(1'b0, start_key, 1'b0, 1'b1, 1'b0);
    check("npc_hp1", STG_BATTLE, 5'b01111, 5'b00001, 1'b0, 1'b0);
    tick_n(30);
    apply(1'b0, start_key, 1'b0, 1'b1, 1'b0);
    check("win_entry", STG_WIN, 5'b01111, 5'b00000, 1'b0, 1'b1);
    apply(1'b0, start_key, 1'b1, 1'b0, 1'b0);
    check("win_hit_ignored", STG_WIN, 5'b01111, 5'b00000, 1'b0, 1'b1);
    tick_n(179);
    check("win_hold_179", STG_WIN, 5'b01111, 5'b00000, 1'b0, 1'b1);
    tick_n(1);
    check("win_timeout", STG_START, 5'b11111, 5'b11111, 1'b0, 1'b1);

    // ---- Double KO -> LOSE ----
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("round2_start", STG_BATTLE, 5'b11111, 5'b11111, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, start_key, 1'b1, 1'b1, 1'b0);
      tick_n(30);
    end
    check("both_hp1", STG_BATTLE, 5'b00001, 5'b00001, 1'b0, 1'b0);
    apply(1'b0, start_key, 1'b1, 1'b1, 1'b0);
    check("double_ko", STG_LOSE, 5'b00000, 5'b00000, 1'b0, 1'b1);

    // ---- LOSE left early by start_key; hits in START ignored ----
    tick_n(10);
    check("lose_hold", STG_LOSE, 5'b00000, 5'b00000, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lose_key_low", STG_LOSE, 5'b00000, 5'b00000, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lose_key_exit", STG_START, 5'b11111, 5'b11111, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("start_hit_ignored", STG_START, 5'b11111, 5'b11111, 1'b0, 1'b1);

    // ---- Reset mid-BATTLE with player HP 2 and timer running ----
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("round3_start", STG_BATTLE, 5'b11111, 5'b11111, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_n(30);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_n(30);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("player_hp2", STG_BATTLE, 5'b00011, 5'b11111, 1'b0, 1'b0);
    tick_n(3);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_battle_reset", STG_START, 5'b11111, 5'b11111, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_start", STG_BATTLE, 5'b11111, 5'b11111, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_reset_timer_clear", STG_BATTLE, 5'b01111, 5'b11111, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stage_controller

// File: doc/stage_controller.md
Name: stage_controller

Overview:
- Game-level sequencer for the fighter display pipeline.
- Owns the stage state machine that drives the colour mapper's stage levels (start_l, battle_l, win_l, lose_l).
- Tracks player and NPC health, with per-side post-hit invulnerability, and presents health as 5-segment thermometer masks to the health-bar renderers.
- Issues round-init and freeze controls to the motion logic.

Parameters:
- MAX_HEALTH, 5: hit points per side at round start; also the width of the thermometer outputs.
- INVULN_FRAMES, 30: frames during which further hits on a side are ignored after that side takes a hit.
- RESULT_FRAMES, 180: frames the WIN/LOSE screen is held before returning to START.
- FRAME_CNT_W, 8: width of the frame timers; must hold max(INVULN_FRAMES, RESULT_FRAMES).

Ports:
- Clk  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  single-cycle pulse once per frame (vertical-blank start), synchronous to Clk.
- start_key  in  1  level from the keycode decoder; its rising edge is detected internally.
- player_hit  in  1  single-cycle pulse: an NPC projectile struck the player.
- npc_hit  in  1  single-cycle pulse: a player projectile struck the NPC.
- start_l  out  1  START stage active.
- battle_l  out  1  BATTLE stage active.
- win_l  out  1  WIN stage active.
- lose_l  out  1  LOSE stage active.
- player_health  out  MAX_HEALTH  thermometer; bit i = 1 iff player HP > i.
- npc_health  out  MAX_HEALTH  thermometer; bit i = 1 iff NPC HP > i.
- round_init  out  1  one-cycle pulse: reset character and projectile positions.
- freeze  out  1  1 whenever the stage is not BATTLE; gates motion logic.

Behaviour:
- All outputs are registered; exactly one stage level is high at any time.
- Reset (synchronous, dominates every other input):
  - state = START; start_l = 1, other stage levels 0.
  - Both HP = MAX_HEALTH, so both thermometers are all ones.
  - Invulnerability and result timers = 0.
  - round_init = 0, freeze = 1.
  - start_key edge register = 0, so a key already held at reset is not an edge.
  - A reset mid-BATTLE or mid-result behaves identically.
- START:
  - A rising edge of start_key at cycle t moves the state to BATTLE at edge t+1.
  - round_init is high for exactly that one cycle.
  - HP reloads to MAX_HEALTH; invulnerability timers clear.
- BATTLE, hit handling:
  - A hit on a side with invulnerability timer 0 decrements that HP by 1, saturating at 0, and loads that timer with INVULN_FRAMES.
  - The HP and thermometer update at the next edge (1-cycle latency).
  - A hit on a side whose timer is nonzero is dropped.
  - Each nonzero timer decrements by 1 on every frame_tick.
  - Simultaneous player_hit and npc_hit in the same cycle are both applied.
  - A hit coinciding with frame_tick while the timer is 1 is dropped: the timer decrement takes priority and the hit sees the pre-tick value.
- BATTLE, exit:
  - The exit decision uses next-cycle HP, so the stage changes on the same edge that HP reaches 0.
  - NPC HP reaches 0 -> WIN.
  - Player HP reaches 0 -> LOSE.
  - Both reach 0 on the same edge -> LOSE (ties go to the NPC).
- WIN / LOSE:
  - The result timer loads 0 on entry and increments on each frame_tick.
  - When it reaches RESULT_FRAMES-1 and frame_tick is seen, the state returns to START.
  - A start_key rising edge also returns to START immediately at the next edge.
  - HP is held frozen (the thermometer keeps showing the final bar).
- Hit pulses outside BATTLE are ignored.
- start_key edges outside START/WIN/LOSE are ignored.
- round_init fires only on START -> BATTLE.
- freeze = ~battle_l, registered together with the state.

Decomposition:
- Shared package faculty_pkg:
  - enum stage_t {ST_START, ST_BATTLE, ST_WIN, ST_LOSE}.
  - Default constants MAX_HEALTH, INVULN_FRAMES, RESULT_FRAMES.
  - Function to_thermo(hp) returning the MAX_HEALTH-wide mask.
- Sub-module health_tracker, instanced once per side. It holds:
  - HP counter with reload and saturating decrement;
  - invulnerability timer;
  - hit qualification;
  - thermometer output and an hp_next_zero flag for the stage FSM.
- The stage FSM, start_key edge detection and result timer remain in stage_controller.

Test Plan:
1. Reset, hold start_key=0 for 100 cycles -> start_l=1, freeze=1, both health=5'b11111, round_init never pulses. Raise start_key -> next edge battle_l=1, round_init high exactly 1 cycle, freeze=0.
2. In BATTLE, npc_hit pulse -> next cycle npc_health=5'b01111. Second npc_hit 5 frame_ticks later -> dropped. npc_hit after 30 frame_ticks -> 5'b00111.
3. Deliver 5 qualified npc_hits -> on the edge npc_health becomes 5'b00000, win_l=1 and battle_l=0 together. After 180 frame_ticks -> start_l=1.
4. Both sides at HP 1, player_hit and npc_hit in the same cycle -> both thermometers become 0 and lose_l=1.
5. In LOSE after 10 frame_ticks, start_key rising edge -> start_l=1 at the next edge. player_hit pulses during START leave health=5'b11111.
6. Assert Reset mid-BATTLE with player HP 2 and a nonzero timer -> next edge start_l=1, both health=5'b11111, timers 0, round_init=0.
